// File: rtl/fp_adder_rr_arbiter_pkg.sv
// Shared types for the round-robin float-adder arbiter: FSM state encoding and data width.
package fp_adder_rr_arbiter_pkg;

  localparam int FP_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    WAIT_Z  = 2'd2,
    DELIVER = 2'd3
  } arb_state_t;

endpackage

// File: rtl/fp_adder_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after rr_ptr, wrapping modulo N_REQ.
module fp_adder_rr_arbiter_rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic             valid,
  output logic [ID_W-1:0]  winner
);

  logic [2*N_REQ-1:0] req_dbl;
  logic [2*N_REQ-1:0] req_rot;
  logic [N_REQ-1:0]   rot_req;
  logic [ID_W-1:0]    offset;
  logic [ID_W:0]      sum;

  // Rotating a doubled copy puts requester rr_ptr at bit 0, so a plain
  // lowest-bit priority encode yields the distance to the winner.
  assign req_dbl = {req, req};
  assign req_rot = req_dbl >> rr_ptr;
  assign rot_req = req_rot[N_REQ-1:0];
  assign valid   = |req;

  always_comb begin
    offset = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot_req[i]) offset = ID_W'(i);
    end
  end

  assign sum    = {1'b0, rr_ptr} + {1'b0, offset};
  assign winner = (sum >= (ID_W + 1)'(N_REQ)) ? ID_W'(sum - (ID_W + 1)'(N_REQ))
                                              : sum[ID_W-1:0];

endmodule

// File: rtl/fp_adder_rr_arbiter.sv
// Shares one strobe/ack float adder among N_REQ requesters with round-robin grants,
// one transaction in flight: capture operands, feed adder, collect sum, return it.
module fp_adder_rr_arbiter
  import fp_adder_rr_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_stb,
  input  logic [FP_W*N_REQ-1:0] req_a,
  input  logic [FP_W*N_REQ-1:0] req_b,
  output logic [N_REQ-1:0]      req_ack,
  output logic [FP_W-1:0]       res_z,
  output logic [N_REQ-1:0]      res_stb,
  input  logic [N_REQ-1:0]      res_ack,
  output logic [FP_W-1:0]       add_a,
  output logic [FP_W-1:0]       add_b,
  output logic                  add_a_stb,
  output logic                  add_b_stb,
  input  logic                  add_a_ack,
  input  logic                  add_b_ack,
  input  logic [FP_W-1:0]       add_z,
  input  logic                  add_z_stb,
  output logic                  add_z_ack,
  output logic                  busy,
  output logic [ID_W-1:0]       gnt_id
);

  arb_state_t        state_reg, state_next;
  logic [ID_W-1:0]   rr_ptr_reg;
  logic              a_done_reg, b_done_reg;
  logic              a_ok, b_ok;
  logic              pick_valid;
  logic [ID_W-1:0]   pick_id;
  logic [N_REQ-1:0]  pick_onehot, gnt_onehot;
  logic [ID_W-1:0]   ptr_after_gnt;
  logic [FP_W-1:0]   op_a [N_REQ];
  logic [FP_W-1:0]   op_b [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign op_a[gi] = req_a[gi*FP_W +: FP_W];
      assign op_b[gi] = req_b[gi*FP_W +: FP_W];
    end
  endgenerate

  fp_adder_rr_arbiter_rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req    (req_stb),
    .rr_ptr (rr_ptr_reg),
    .valid  (pick_valid),
    .winner (pick_id)
  );

  assign pick_onehot   = N_REQ'(1) << pick_id;
  assign gnt_onehot    = N_REQ'(1) << gnt_id;
  assign ptr_after_gnt = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + ID_W'(1);

  assign busy      = (state_reg != IDLE);
  assign add_z_ack = (state_reg == WAIT_Z) && add_z_stb;

  // An operand counts as delivered once its ack has been seen, now or earlier.
  assign a_ok = a_done_reg | add_a_ack;
  assign b_ok = b_done_reg | add_b_ack;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (pick_valid)      state_next = SEND;
      SEND:    if (a_ok && b_ok)    state_next = WAIT_Z;
      WAIT_Z:  if (add_z_stb)       state_next = DELIVER;
      DELIVER: if (res_ack[gnt_id]) state_next = IDLE;
      default:                      state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= '0;
      gnt_id     <= '0;
      req_ack    <= '0;
      res_stb    <= '0;
      res_z      <= '0;
      add_a      <= '0;
      add_b      <= '0;
      add_a_stb  <= 1'b0;
      add_b_stb  <= 1'b0;
      a_done_reg <= 1'b0;
      b_done_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      req_ack   <= '0;
      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            add_a      <= op_a[pick_id];
            add_b      <= op_b[pick_id];
            gnt_id     <= pick_id;
            req_ack    <= pick_onehot;
            add_a_stb  <= 1'b1;
            add_b_stb  <= 1'b1;
            a_done_reg <= 1'b0;
            b_done_reg <= 1'b0;
          end
        end
        SEND: begin
          if (add_a_ack) begin
            add_a_stb  <= 1'b0;
            a_done_reg <= 1'b1;
          end
          if (add_b_ack) begin
            add_b_stb  <= 1'b0;
            b_done_reg <= 1'b1;
          end
        end
        WAIT_Z: begin
          if (add_z_stb) begin
            res_z   <= add_z;
            res_stb <= gnt_onehot;
          end
        end
        DELIVER: begin
          if (res_ack[gnt_id]) begin
            res_stb    <= '0;
            rr_ptr_reg <= ptr_after_gnt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_adder_rr_arbiter.sv
// Bench for fp_adder_rr_arbiter: behavioural strobe/ack adder model plus grant and result scoreboards.
module tb_fp_adder_rr_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_stb;
  logic [32*N-1:0] req_a, req_b;
  logic [N-1:0]    req_ack;
  logic [31:0]     res_z;
  logic [N-1:0]    res_stb;
  logic [N-1:0]    res_ack;
  logic [31:0]     add_a, add_b;
  logic            add_a_stb, add_b_stb;
  logic            add_a_ack, add_b_ack;
  logic [31:0]     add_z;
  logic            add_z_stb, add_z_ack;
  logic            busy;
  logic [IW-1:0]   gnt_id;

  always #5 clk = ~clk;

  fp_adder_rr_arbiter #(.N_REQ(N), .ID_W(IW)) dut (
    .clk(clk), .rst(rst),
    .req_stb(req_stb), .req_a(req_a), .req_b(req_b), .req_ack(req_ack),
    .res_z(res_z), .res_stb(res_stb), .res_ack(res_ack),
    .add_a(add_a), .add_b(add_b), .add_a_stb(add_a_stb), .add_b_stb(add_b_stb),
    .add_a_ack(add_a_ack), .add_b_ack(add_b_ack),
    .add_z(add_z), .add_z_stb(add_z_stb), .add_z_ack(add_z_ack),
    .busy(busy), .gnt_id(gnt_id)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Stand-in adder: exact sums for the known vectors, otherwise an
  // order-sensitive mix so swapped or stale operands are visible.
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3f000000 && b == 32'h3f000000) return 32'h3f800000;
    if (a == 32'h3e19999a && b == 32'hbe19999a) return 32'h00000000;
    if (b == 32'h0) return a;
    return a - b;
  endfunction

  // ---------------- adder model ----------------
  int          a_dly = 0, b_dly = 0;
  int          a_cnt, b_cnt, z_cnt;
  logic        a_got, b_got;
  logic [31:0] ma, mb;
  int          hs_a = 0, hs_b = 0, reraise = 0;

  always @(posedge clk) begin
    if (rst) begin
      add_a_ack <= 1'b0; add_b_ack <= 1'b0; add_z_stb <= 1'b0; add_z <= '0;
      a_got <= 1'b0; b_got <= 1'b0; a_cnt <= 0; b_cnt <= 0; z_cnt <= 0;
    end else begin
      if (add_a_stb && a_got) reraise <= reraise + 1;
      if (add_b_stb && b_got) reraise <= reraise + 1;
      if (add_a_stb && add_a_ack) begin
        ma <= add_a; a_got <= 1'b1; add_a_ack <= 1'b0; hs_a <= hs_a + 1;
      end else if (add_a_stb && !a_got && !add_a_ack) begin
        if (a_cnt >= a_dly) add_a_ack <= 1'b1; else a_cnt <= a_cnt + 1;
      end
      if (add_b_stb && add_b_ack) begin
        mb <= add_b; b_got <= 1'b1; add_b_ack <= 1'b0; hs_b <= hs_b + 1;
      end else if (add_b_stb && !b_got && !add_b_ack) begin
        if (b_cnt >= b_dly) add_b_ack <= 1'b1; else b_cnt <= b_cnt + 1;
      end
      if (a_got && b_got && !add_z_stb) begin
        if (z_cnt >= 2) begin add_z <= fadd(ma, mb); add_z_stb <= 1'b1; end
        else z_cnt <= z_cnt + 1;
      end
      if (add_z_stb && add_z_ack) begin
        add_z_stb <= 1'b0; a_got <= 1'b0; b_got <= 1'b0;
        a_cnt <= 0; b_cnt <= 0; z_cnt <= 0;
      end
    end
  end

  // ---------------- scoreboards and monitor ----------------
  int          exp_gnt[$];
  int          exp_res_id[$];
  logic [31:0] exp_res_z[$];
  logic        ack_en = 1'b1;
  logic [N-1:0] stray_ack = '0;

  initial begin
    int g, id;
    logic [31:0] z;
    res_ack = '0;
    forever begin
      @(negedge clk);
      res_ack = stray_ack;
      if (!rst && req_ack != '0) begin
        if (exp_gnt.size() == 0) check("gnt_unexpected", 32'(req_ack), 32'h0);
        else begin
          g = exp_gnt.pop_front();
          check("gnt_onehot", 32'(req_ack), 32'(1) << g);
        end
      end
      if (!rst && ack_en && res_stb != '0) begin
        if (exp_res_id.size() == 0) check("res_unexpected", 32'(res_stb), 32'h0);
        else begin
          id = exp_res_id.pop_front();
          z  = exp_res_z.pop_front();
          check("res_stb", 32'(res_stb), 32'(1) << id);
          check("res_z", res_z, z);
          $display("txn id=%0d res_stb=%b res_z=%h exp=%h", id, res_stb, res_z, z);
          res_ack = res_stb;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic request(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    req_stb[i] = 1'b1;
    exp_res_id.push_back(i);
    exp_res_z.push_back(fadd(a, b));
  endtask

  task automatic wait_ack_drop(input int i);
    int n = 0;
    while (!req_ack[i] && n < 60) begin @(negedge clk); n++; end
    check($sformatf("req_ack_seen%0d", i), 32'(req_ack[i]), 32'h1);
    req_stb[i] = 1'b0;
    req_a[i*32 +: 32] = 32'hdeadbeef;
    req_b[i*32 +: 32] = 32'h12345678;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while ((busy || exp_res_id.size() != 0) && n < 200) begin @(negedge clk); n++; end
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_pending"}, 32'(exp_res_id.size()), 32'h0);
  endtask

  task automatic wait_deliver();
    int n = 0;
    while (res_stb == '0 && n < 60) begin @(negedge clk); n++; end
    check("deliver_reached", 32'(res_stb != '0), 32'h1);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_req_ack"}, 32'(req_ack), 32'h0);
    check({tag, "_res_stb"}, 32'(res_stb), 32'h0);
    check({tag, "_res_z"}, res_z, 32'h0);
    check({tag, "_stbs"}, {30'h0, add_a_stb, add_b_stb}, 32'h0);
    check({tag, "_z_ack"}, 32'(add_z_ack), 32'h0);
    check({tag, "_gnt_id"}, 32'(gnt_id), 32'h0);
  endtask

  task automatic clear_expect();
    exp_gnt.delete();
    exp_res_id.delete();
    exp_res_z.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int cnt, n, hs_a0, hs_b0;
    logic [N-1:0] hold_stb;
    logic [31:0]  hold_z;

    rst = 1'b1; req_stb = '0; req_a = '0; req_b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_outs("reset");

    // single request on lane 0
    exp_gnt.push_back(0);
    request(0, 32'h3f000000, 32'h3f000000);
    wait_ack_drop(0);
    wait_idle("t1");

    // lane 1, twice
    exp_gnt.push_back(1);
    request(1, 32'h3e19999a, 32'hbe19999a);
    wait_ack_drop(1);
    wait_idle("t2a");
    exp_gnt.push_back(1);
    request(1, 32'h3f000000, 32'h00000000);
    wait_ack_drop(1);
    wait_idle("t2b");

    // pointer now at 2: lanes 0 and 3 together -> 3 first, then 0
    exp_gnt.push_back(3); exp_gnt.push_back(0);
    request(3, 32'h40400000, 32'h00000300);
    request(0, 32'h40800000, 32'h00000400);
    wait_ack_drop(3);
    wait_ack_drop(0);
    wait_idle("rr");
    check("gnt_id_last", 32'(gnt_id), 32'h0);

    // all lanes held high across reset: grants 0,1,2,3,0
    rst = 1'b1;
    clear_expect();
    foreach (exp_gnt[k]) exp_gnt.delete(k);
    for (int i = 0; i < N; i++) begin
      exp_gnt.push_back(i);
      request(i, 32'h41000000 + 32'(i << 4), 32'h00001000 * 32'(i));
    end
    exp_gnt.push_back(0);
    exp_res_id.push_back(0);
    exp_res_z.push_back(fadd(32'h41000000, 32'h0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cnt = 0; n = 0;
    while (cnt < 5 && n < 300) begin
      @(negedge clk); n++;
      if (req_ack != '0) cnt++;
    end
    check("t3_grants", 32'(cnt), 32'h5);
    req_stb = '0;
    wait_idle("t3");

    // ack ordering: b well before a, then both together
    hs_a0 = hs_a; hs_b0 = hs_b;
    a_dly = 3; b_dly = 0;
    exp_gnt.push_back(2);
    request(2, 32'h3fc00000, 32'h00000010);
    wait_ack_drop(2);
    wait_idle("t4a");
    a_dly = 0; b_dly = 0;
    exp_gnt.push_back(2);
    request(2, 32'h3fe00000, 32'h00000020);
    wait_ack_drop(2);
    wait_idle("t4b");
    check("t4_hs_a", 32'(hs_a - hs_a0), 32'h2);
    check("t4_hs_b", 32'(hs_b - hs_b0), 32'h2);
    check("t4_reraise", 32'(reraise), 32'h0);

    // result held back 10 cycles while lane 1 waits; stray acks ignored
    ack_en = 1'b0;
    exp_gnt.push_back(3); exp_gnt.push_back(1);
    request(3, 32'h42000000, 32'h00000033);
    request(1, 32'h42100000, 32'h00000011);
    wait_ack_drop(3);
    wait_deliver();
    hold_stb = res_stb; hold_z = res_z;
    stray_ack = ~res_stb;
    check("t5_stb_lane", 32'(hold_stb), 32'h8);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("t5_res_stb", 32'(res_stb), 32'(hold_stb));
      check("t5_res_z", res_z, hold_z);
      check("t5_busy", 32'(busy), 32'h1);
      check("t5_z_ack", 32'(add_z_ack), 32'h0);
      check("t5_no_grant", 32'(req_ack), 32'h0);
    end
    stray_ack = '0;
    ack_en = 1'b1;
    wait_ack_drop(1);
    wait_idle("t5");

    // reset in SEND, pointer was 2
    a_dly = 5;
    exp_gnt.push_back(2);
    request(2, 32'h43000000, 32'h00000001);
    wait_ack_drop(2);
    check("t6_in_send", 32'(add_a_stb), 32'h1);
    rst = 1'b1;
    clear_expect();
    @(negedge clk);
    check_reset_outs("t6_send");
    rst = 1'b0;
    a_dly = 0;
    exp_gnt.push_back(1); exp_gnt.push_back(3);
    request(1, 32'h43100000, 32'h00000002);
    request(3, 32'h43300000, 32'h00000003);
    wait_ack_drop(1);
    wait_ack_drop(3);
    wait_idle("t6a");

    // reset in DELIVER
    ack_en = 1'b0;
    exp_gnt.push_back(2);
    request(2, 32'h44000000, 32'h00000004);
    wait_ack_drop(2);
    wait_deliver();
    rst = 1'b1;
    clear_expect();
    @(negedge clk);
    check_reset_outs("t6_deliver");
    rst = 1'b0;
    ack_en = 1'b1;
    exp_gnt.push_back(1); exp_gnt.push_back(3);
    request(1, 32'h44100000, 32'h00000005);
    request(3, 32'h44300000, 32'h00000006);
    wait_ack_drop(1);
    wait_ack_drop(3);
    wait_idle("t6b");
    check("gnt_queue_empty", 32'(exp_gnt.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
